// File: rtl/rt_mem_readback_ctrl.sv
// ---------------------------------------------------------------------------
// rt_mem_readback_ctrl
//
// Read engine for port B of the racetrack/LiM data memory. Walks a region of
// num_words_i words starting at base_addr_i. For each word it issues a single
// read (one-cycle mem_en_o strobe) and waits for mem_rvalid_i. It then presents
// the captured word, together with its byte address, on an output stream. The
// block is used to dump memory after a run and to read back the region that
// was loaded over port B.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start_i           start request, only looked at while idle
//   abort_i           synchronous abort, wins over every other transition
//   base_addr_i       first byte address (bits [1:0] are ignored)
//   num_words_i       number of words to read (0 = immediate done pulse)
//   busy_o            high whenever the engine is not idle
//   done_o            one-cycle completion pulse (not raised on abort)
//   err_timeout_o     sticky, set when a read got no rvalid in time;
//                     cleared by the next accepted start
//   mem_en_o          port B access strobe, one cycle per word
//   mem_we_o          port B write enable, tied low (read-only engine)
//   mem_be_o          port B byte enables, tied all-ones
//   mem_addr_o        port B byte address (registered)
//   mem_rvalid_i      read data valid from memory
//   mem_rdata_i       read data from memory
//   out_valid_o       stream valid
//   out_ready_i       stream ready
//   out_data_o        captured word
//   out_addr_o        byte address of out_data_o
//   dbg_state_o       current FSM state, for checkers and debug
//
// Stream handshake: a beat transfers on a rising clk edge where out_valid_o
// and out_ready_i are both high. Once out_valid_o is raised it stays high, and
// out_data_o/out_addr_o stay unchanged, until that transfer happens. The only
// exceptions are abort_i and reset. out_valid_o never depends
// combinationally on out_ready_i.
// ---------------------------------------------------------------------------
module rt_mem_readback_ctrl #(
  parameter int ADDR_WIDTH     = 22,
  parameter int DATA_WIDTH     = 32,
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic                    abort_i,
  input  logic [ADDR_WIDTH-1:0]   base_addr_i,
  input  logic [CNT_WIDTH-1:0]    num_words_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_timeout_o,
  output logic                    mem_en_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [DATA_WIDTH-1:0]   out_data_o,
  output logic [ADDR_WIDTH-1:0]   out_addr_o,
  output logic [2:0]              dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_OUT  = 3'd3,
    S_GAP  = 3'd4,
    S_DONE = 3'd5
  } state_e;

  // The timeout counter only has to hold 0..TIMEOUT_CYCLES-1.
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [CNT_WIDTH-1:0]    remaining_q, remaining_d;
  logic [TO_W-1:0]         to_cnt_q, to_cnt_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    mem_en_q, mem_en_d;
  logic                    out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic [ADDR_WIDTH-1:0]   out_addr_q, out_addr_d;
  logic                    zero_done;

  // Word alignment: the two low address bits are dropped.
  logic unused_base_lsbs;
  assign unused_base_lsbs = ^base_addr_i[1:0];

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    to_cnt_d    = to_cnt_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    zero_done   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          err_d = 1'b0;
          if (num_words_i != '0) begin
            addr_d      = {base_addr_i[ADDR_WIDTH-1:2], 2'b00};
            remaining_d = num_words_i;
            state_d     = S_REQ;
          end else begin
            // Empty request: acknowledge it without touching memory.
            zero_done = 1'b1;
          end
        end
      end
      S_REQ: begin
        to_cnt_d = '0;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        if (mem_rvalid_i) begin
          out_valid_d = 1'b1;
          out_data_d  = mem_rdata_i;
          out_addr_d  = addr_q;
          state_d     = S_OUT;
        end else if (to_cnt_q == TO_LAST) begin
          // This was the last WAIT cycle allowed. Give up on the whole
          // transfer. Any rvalid that arrives later lands outside WAIT and is
          // dropped.
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      S_OUT: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          addr_d      = addr_q + ADDR_WIDTH'(4);
          remaining_d = remaining_q - CNT_WIDTH'(1);
          // remaining_q counts words still owed, including this one. Testing
          // for 1 before the decrement means the counter never wraps, even
          // for the largest count.
          state_d     = (remaining_q == CNT_WIDTH'(1)) ? S_DONE : S_GAP;
        end
      end
      S_GAP: begin
        state_d = S_REQ;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides everything. The engine drops the stream and any memory
    // access, reports no done, and leaves the error flag untouched.
    if (abort_i) begin
      state_d     = S_IDLE;
      addr_d      = addr_q;
      remaining_d = remaining_q;
      to_cnt_d    = to_cnt_q;
      err_d       = err_q;
      out_valid_d = 1'b0;
      zero_done   = 1'b0;
    end

    // The strobe-style outputs are decoded from the next state, so they line
    // up exactly with the state they belong to while coming straight from
    // flops.
    mem_en_d = (state_d == S_REQ);
    busy_d   = (state_d != S_IDLE);
    done_d   = zero_done || (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      to_cnt_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_en_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      to_cnt_q    <= to_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      mem_en_q    <= mem_en_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign err_timeout_o = err_q;
  assign mem_en_o      = mem_en_q;
  assign mem_we_o      = 1'b0;
  assign mem_be_o      = '1;
  assign mem_addr_o    = addr_q;
  assign out_valid_o   = out_valid_q;
  assign out_data_o    = out_data_q;
  assign out_addr_o    = out_addr_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_rt_mem_readback_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for rt_mem_readback_ctrl.
// Negedge block: memory responder (fixed latency, rdata = addr ^ key), stream
// sink (ready policy) and activity monitor. Scenario tasks drive start/abort
// and compare the monitor's record against a scoreboard built from the
// address-walk rules.
// ---------------------------------------------------------------------------
module tb_rt_mem_readback_ctrl;
  localparam int AW = 22;
  localparam int DW = 32;
  localparam int CW = 16;
  localparam int TO = 64;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic          abort_i = 1'b0;
  logic [AW-1:0] base_addr_i = '0;
  logic [CW-1:0] num_words_i = '0;
  logic          busy_o, done_o, err_timeout_o, mem_en_o, mem_we_o;
  logic [DW/8-1:0] mem_be_o;
  logic [AW-1:0] mem_addr_o;
  logic          mem_rvalid_i = 1'b0;
  logic [DW-1:0] mem_rdata_i = '0;
  logic          out_valid_o;
  logic          out_ready_i = 1'b1;
  logic [DW-1:0] out_data_o;
  logic [AW-1:0] out_addr_o;
  logic [2:0]    dbg_state_o;

  always #5 clk = ~clk;

  rt_mem_readback_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
    .base_addr_i(base_addr_i), .num_words_i(num_words_i),
    .busy_o(busy_o), .done_o(done_o), .err_timeout_o(err_timeout_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .out_addr_o(out_addr_o), .dbg_state_o(dbg_state_o)
  );

  // ---------------- bench state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int            mem_lat = 1;
  int            mem_delay = 0;
  bit            mem_never = 1'b0;
  bit            force_rv = 1'b0;
  logic [AW-1:0] mem_addr_lat = '0;
  logic [DW-1:0] mem_key = '0;

  bit ready_rand = 1'b0;
  int stall_beat = -1;
  int stall_len  = 0;
  int stall_cnt  = 0;

  logic [AW-1:0] got_addr_q[$];
  logic [DW-1:0] got_data_q[$];
  int            en_cyc_q[$];
  int en_cnt = 0, en_wide = 0, done_cnt = 0, valid_cyc = 0, stab_viol = 0;
  int en_first_cyc = -1, first_valid_cyc = -1, err_rise_cyc = -1;
  bit prev_en = 1'b0, prev_err = 1'b0, hold_chk = 1'b0;
  logic [AW-1:0] held_addr = '0;
  logic [DW-1:0] held_data = '0;

  // ---------------- memory responder, sink and monitor ----------------
  always @(negedge clk) begin
    cyc++;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = DW'($urandom);
    if (mem_delay > 0) begin
      mem_delay--;
      if (mem_delay == 0) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = DW'(mem_addr_lat) ^ mem_key;
      end
    end
    if (force_rv) mem_rvalid_i = 1'b1;
    if (mem_en_o) begin
      if (en_cnt == 0) en_first_cyc = cyc;
      en_cnt++;
      en_cyc_q.push_back(cyc);
      if (prev_en) en_wide++;
      if (!mem_never) begin
        mem_delay    = mem_lat;
        mem_addr_lat = mem_addr_o;
      end
    end
    prev_en = mem_en_o;

    out_ready_i = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (out_valid_o && got_addr_q.size() == stall_beat && stall_cnt < stall_len) begin
      out_ready_i = 1'b0;
      stall_cnt++;
    end
    if (hold_chk && (out_valid_o !== 1'b1 || out_addr_o !== held_addr || out_data_o !== held_data))
      stab_viol++;
    hold_chk  = out_valid_o && !out_ready_i;
    held_addr = out_addr_o;
    held_data = out_data_o;

    if (out_valid_o) begin
      if (valid_cyc == 0) first_valid_cyc = cyc;
      valid_cyc++;
    end
    if (out_valid_o && out_ready_i) begin
      got_addr_q.push_back(out_addr_o);
      got_data_q.push_back(out_data_o);
    end
    if (done_o) done_cnt++;
    if (err_timeout_o && !prev_err) err_rise_cyc = cyc;
    prev_err = err_timeout_o;
  end

  // ---------------- driver tasks ----------------
  task automatic clear_mon();
    got_addr_q.delete();
    got_data_q.delete();
    en_cyc_q.delete();
    en_cnt = 0; en_wide = 0; done_cnt = 0; valid_cyc = 0; stab_viol = 0;
    en_first_cyc = -1; first_valid_cyc = -1; err_rise_cyc = -1;
    stall_cnt = 0; hold_chk = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0; force_rv = 1'b0;
    mem_never = 1'b0; ready_rand = 1'b0; stall_len = 0; stall_beat = -1;
    repeat (3) @(negedge clk);
    mem_delay = 0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    clear_mon();
  endtask

  // Runs one complete transfer and checks it against the scoreboard.
  // bs > 0: pulse start (with a different count) bs cycles into the transfer.
  task automatic run_transfer(input logic [AW-1:0] base, input int num, input int lat,
                              input bit rr, input int sb, input int sl,
                              input logic [DW-1:0] key, input int bs, input string tag);
    logic [AW-1:0] exp_addr_q[$];
    logic [DW-1:0] exp_data_q[$];
    logic [AW-1:0] a;
    int budget, n, m;
    @(posedge clk); #1;
    clear_mon();
    mem_lat = lat; mem_key = key; ready_rand = rr; stall_beat = sb; stall_len = sl;
    a = {base[AW-1:2], 2'b00};
    for (int k = 0; k < num; k++) begin
      exp_addr_q.push_back(a);
      exp_data_q.push_back(DW'(a) ^ key);
      a = a + AW'(4);  // wraps at 2^AW by width
    end
    @(negedge clk);
    base_addr_i = base; num_words_i = CW'(num); start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; base_addr_i = AW'($urandom); num_words_i = CW'($urandom);
    n_checks++;
    if (mem_en_o !== 1'b1) begin
      n_fail++; $display("FAIL %s start_to_en: mem_en_o=%b exp 1", tag, mem_en_o);
    end
    n_checks++;
    if (mem_addr_o !== exp_addr_q[0]) begin
      n_fail++; $display("FAIL %s first_mem_addr: got %h exp %h", tag, mem_addr_o, exp_addr_q[0]);
    end
    budget = num * (lat + 6 + sl) * 3 + 200;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge clk); n++; #1;
      if (bs > 0 && n == bs) begin start_i = 1'b1; num_words_i = CW'(num + 4); end
      else start_i = 1'b0;
    end
    start_i = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (done_cnt != 1) begin
      n_fail++; $display("FAIL %s done_pulses: got %0d exp 1", tag, done_cnt);
    end
    n_checks++;
    if (busy_o !== 1'b0 || err_timeout_o !== 1'b0) begin
      n_fail++; $display("FAIL %s end_flags: busy=%b err=%b exp 0 0", tag, busy_o, err_timeout_o);
    end
    n_checks++;
    if (en_cnt != num || en_wide != 0) begin
      n_fail++; $display("FAIL %s mem_en: pulses=%0d wide=%0d exp %0d 0", tag, en_cnt, en_wide, num);
    end
    n_checks++;
    if (got_addr_q.size() != num) begin
      n_fail++; $display("FAIL %s beat_count: got %0d exp %0d", tag, got_addr_q.size(), num);
    end
    n_checks++;
    if (stab_viol != 0) begin
      n_fail++; $display("FAIL %s stall_stability: violations %0d exp 0", tag, stab_viol);
    end
    n_checks++;
    if (first_valid_cyc - en_first_cyc != lat + 1) begin
      n_fail++; $display("FAIL %s rvalid_to_valid: got %0d exp %0d", tag, first_valid_cyc - en_first_cyc, lat + 1);
    end
    m = (got_addr_q.size() < num) ? got_addr_q.size() : num;
    for (int k = 0; k < m; k++) begin
      n_checks++;
      if (got_addr_q[k] !== exp_addr_q[k] || got_data_q[k] !== exp_data_q[k]) begin
        n_fail++;
        $display("FAIL %s beat%0d: got %h/%h exp %h/%h", tag, k, got_addr_q[k], got_data_q[k],
                 exp_addr_q[k], exp_data_q[k]);
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    n_checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || err_timeout_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: busy=%b done=%b err=%b exp 0", busy_o, done_o, err_timeout_o);
    end
    n_checks++;
    if (mem_en_o !== 1'b0 || mem_we_o !== 1'b0 || mem_be_o !== 4'hF || mem_addr_o !== '0) begin
      n_fail++; $display("FAIL reset_mem: en=%b we=%b be=%h addr=%h exp 0 0 f 0",
                         mem_en_o, mem_we_o, mem_be_o, mem_addr_o);
    end
    n_checks++;
    if (out_valid_o !== 1'b0 || out_data_o !== '0 || out_addr_o !== '0) begin
      n_fail++; $display("FAIL reset_stream: valid=%b data=%h addr=%h exp 0", out_valid_o, out_data_o, out_addr_o);
    end
  endtask

  task automatic test_basic();
    run_transfer(22'h180, 4, 3, 1'b0, -1, 0, 32'hA5A5_A5A5, 0, "basic");
  endtask

  task automatic test_stall();
    run_transfer(22'h180, 4, 3, 1'b0, 1, 5, 32'hA5A5_A5A5, 0, "stall");
    n_checks++;
    if (stall_cnt != 5) begin
      n_fail++; $display("FAIL stall_applied: got %0d exp 5", stall_cnt);
    end
  endtask

  task automatic test_wrap();
    run_transfer(22'h3FFFFC, 2, 2, 1'b0, -1, 0, 32'h1357_9BDF, 0, "wrap");
  endtask

  task automatic test_back_to_back();
    run_transfer(22'h000403, 5, 1, 1'b0, -1, 0, 32'h0BAD_F00D, 0, "b2b");
    for (int k = 1; k < en_cyc_q.size(); k++) begin
      n_checks++;
      if (en_cyc_q[k] - en_cyc_q[k-1] != 4) begin
        n_fail++; $display("FAIL b2b_period%0d: got %0d exp 4", k, en_cyc_q[k] - en_cyc_q[k-1]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++)
      run_transfer(AW'($urandom), $urandom_range(1, 6), $urandom_range(1, 5), 1'b1, -1, 0,
                   DW'($urandom), 0, $sformatf("rand%0d", i));
  endtask

  task automatic test_timeout();
    int n;
    @(posedge clk); #1;
    clear_mon();
    mem_never = 1'b1; ready_rand = 1'b0; stall_len = 0;
    @(negedge clk); base_addr_i = 22'h100; num_words_i = 16'd3; start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    n = 0;
    while (done_cnt == 0 && n < 300) begin @(posedge clk); n++; end
    repeat (2) @(negedge clk);
    n_checks++;
    if (err_timeout_o !== 1'b1 || done_cnt != 1) begin
      n_fail++; $display("FAIL timeout_flag: err=%b done=%0d exp 1 1", err_timeout_o, done_cnt);
    end
    // en is seen in the REQ cycle; WAIT starts at the next edge and the
    // error lands TO edges later, so the flag shows up TO+1 samples after en.
    n_checks++;
    if (err_rise_cyc - en_first_cyc != TO + 1) begin
      n_fail++; $display("FAIL timeout_latency: got %0d exp %0d", err_rise_cyc - en_first_cyc, TO + 1);
    end
    n_checks++;
    if (got_addr_q.size() != 0 || en_cnt != 1 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL timeout_activity: beats=%0d en=%0d busy=%b exp 0 1 0",
                         got_addr_q.size(), en_cnt, busy_o);
    end
    mem_never = 1'b0;
    run_transfer(22'h200, 1, 2, 1'b0, -1, 0, 32'h1234_5678, 0, "after_timeout");
  endtask

  task automatic test_abort();
    int n;
    @(posedge clk); #1;
    clear_mon();
    mem_lat = 8; mem_key = 32'hCAFE_0001; ready_rand = 1'b0; stall_len = 0;
    @(negedge clk); base_addr_i = 22'h800; num_words_i = 16'd8; start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    n = 0;
    while (en_cnt < 2 && n < 100) begin @(posedge clk); n++; end
    repeat (2) @(negedge clk);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    n_checks++;
    if (busy_o !== 1'b0 || mem_en_o !== 1'b0 || out_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL abort_next: busy=%b en=%b valid=%b exp 0", busy_o, mem_en_o, out_valid_o);
    end
    repeat (20) @(negedge clk);
    n_checks++;
    if (got_addr_q.size() != 1 || done_cnt != 0 || err_timeout_o !== 1'b0) begin
      n_fail++; $display("FAIL abort_after: beats=%0d done=%0d err=%b exp 1 0 0",
                         got_addr_q.size(), done_cnt, err_timeout_o);
    end
    n_checks++;
    if (busy_o !== 1'b0 || en_cnt != 2) begin
      n_fail++; $display("FAIL abort_idle: busy=%b en=%0d exp 0 2", busy_o, en_cnt);
    end
  endtask

  task automatic test_zero();
    @(posedge clk); #1;
    clear_mon();
    @(negedge clk); base_addr_i = AW'($urandom); num_words_i = '0; start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    n_checks++;
    if (done_o !== 1'b1 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL zero_done: done=%b busy=%b exp 1 0", done_o, busy_o);
    end
    @(negedge clk);
    n_checks++;
    if (done_o !== 1'b0) begin
      n_fail++; $display("FAIL zero_done_width: done=%b exp 0", done_o);
    end
    repeat (4) @(negedge clk);
    n_checks++;
    if (en_cnt != 0 || done_cnt != 1) begin
      n_fail++; $display("FAIL zero_activity: en=%0d done=%0d exp 0 1", en_cnt, done_cnt);
    end
  endtask

  task automatic test_start_busy();
    run_transfer(22'h1F0, 3, 2, 1'b0, -1, 0, 32'h5555_AAAA, 4, "start_busy");
  endtask

  task automatic test_max_count();
    logic [AW-1:0] a;
    int n;
    @(posedge clk); #1;
    clear_mon();
    mem_lat = 1; mem_key = 32'h0F0F_1234; ready_rand = 1'b0; stall_len = 0;
    @(negedge clk); base_addr_i = 22'h3FFFF0; num_words_i = 16'hFFFF; start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    n = 0;
    while (got_addr_q.size() < 6 && n < 200) begin @(posedge clk); n++; end
    @(negedge clk);
    n_checks++;
    if (busy_o !== 1'b1 || done_cnt != 0) begin
      n_fail++; $display("FAIL max_busy: busy=%b done=%0d exp 1 0", busy_o, done_cnt);
    end
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (busy_o !== 1'b0 || done_cnt != 0 || got_addr_q.size() < 6) begin
      n_fail++; $display("FAIL max_abort: busy=%b done=%0d beats=%0d exp 0 0 >=6",
                         busy_o, done_cnt, got_addr_q.size());
    end
    a = 22'h3FFFF0;
    for (int k = 0; k < got_addr_q.size(); k++) begin
      n_checks++;
      if (got_addr_q[k] !== a || got_data_q[k] !== (DW'(a) ^ mem_key)) begin
        n_fail++; $display("FAIL max_beat%0d: got %h/%h exp %h/%h", k, got_addr_q[k], got_data_q[k],
                           a, DW'(a) ^ mem_key);
      end
      a = a + AW'(4);
    end
  endtask

  task automatic test_spurious();
    @(posedge clk); #1;
    clear_mon();
    @(negedge clk); force_rv = 1'b1;
    repeat (3) @(negedge clk);
    force_rv = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (valid_cyc != 0 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL spurious_rvalid: valid_cycles=%0d busy=%b exp 0 0", valid_cyc, busy_o);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    @(posedge clk); #1;
    clear_mon();
    mem_lat = 3; mem_key = 32'h7777_0000; ready_rand = 1'b0; stall_len = 0;
    @(negedge clk); base_addr_i = 22'h040; num_words_i = 16'd4; start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    n = 0;
    while (en_cnt < 2 && n < 100) begin @(posedge clk); n++; end
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy_o !== 1'b0 || mem_en_o !== 1'b0 || out_valid_o !== 1'b0 || done_o !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_flags: busy=%b en=%b valid=%b done=%b exp 0",
                         busy_o, mem_en_o, out_valid_o, done_o);
    end
    n_checks++;
    if (mem_addr_o !== '0 || out_addr_o !== '0 || out_data_o !== '0) begin
      n_fail++; $display("FAIL rstmid_regs: maddr=%h oaddr=%h odata=%h exp 0", mem_addr_o, out_addr_o, out_data_o);
    end
    @(negedge clk);
    mem_delay = 0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_wrap();
    test_back_to_back();
    test_random();
    test_timeout();
    test_abort();
    test_zero();
    test_start_busy();
    test_max_count();
    test_spurious();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
